// File: rtl/puf_eval_ctrl_if.sv
// ---------------------------------------------------------------------------
// puf_eval_ctrl_if
//
// Purpose: groups the request/response handshake of the PUF evaluation
// controller so the controller and its requester share one bundle.
//
// Signals:
//   start        requester -> controller  request an evaluation
//   challenge    requester -> controller  N-bit challenge, captured on start
//   resp_ready   requester -> controller  requester accepts the response
//   busy         controller -> requester  high whenever not idle
//   resp_valid   controller -> requester  response available
//   resp_bit     controller -> requester  response bit
//   resp_margin  controller -> requester  |cnt_a - cnt_b| of the response
//
// Modports: master (requester side), slave (controller side).
// ---------------------------------------------------------------------------
interface puf_eval_ctrl_if #(
    parameter int N = 128
);
    logic         start;
    logic [N-1:0] challenge;
    logic         resp_ready;
    logic         busy;
    logic         resp_valid;
    logic         resp_bit;
    logic [15:0]  resp_margin;

    modport master (
        output start,
        output challenge,
        output resp_ready,
        input  busy,
        input  resp_valid,
        input  resp_bit,
        input  resp_margin
    );

    modport slave (
        input  start,
        input  challenge,
        input  resp_ready,
        output busy,
        output resp_valid,
        output resp_bit,
        output resp_margin
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// ---------------------------------------------------------------------------
// puf_eval_ctrl
//
// Purpose: evaluation controller for the dual-mode demux/mux PUF delay chain.
// A challenge is captured and driven onto the chain select lines, the two
// end-of-chain pulse counters are cleared, a fixed train of PULSES pulses is
// launched into the chain, and after a drain period both counters are
// compared. The response bit (cnt_a > cnt_b) and the margin |cnt_a - cnt_b|
// are returned over a valid/ready handshake.
//
// Optional feature macro: PUF_MAJORITY_EN
//   defined   - three back-to-back rounds with the same challenge; the
//               response bit is the majority vote of the three round bits
//               and the margin is the smallest of the three round margins.
//   undefined - a single round; no vote or round-counter logic exists.
//
// Parameters:
//   N           challenge width / chain stage count
//   PULSES      excitation pulses per round (1..32767)
//   SETTLE_CYC  cycles between select load and first pulse (>= 1)
//   DRAIN_CYC   cycles after the last pulse before sampling (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   bus          slave side of puf_eval_ctrl_if (start/challenge in,
//                busy and the response handshake out)
//   o_puf_sel    out  registered select vector to the chain
//   o_puf_in     out  registered excitation drive to the chain input
//   o_puf_reset  out  registered clear to both chain counters
//   i_cnt_a      in   counter value at the m-path end
//   i_cnt_b      in   counter value at the n-path end
// ---------------------------------------------------------------------------
module puf_eval_ctrl #(
    parameter int N          = 128,
    parameter int PULSES     = 64,
    parameter int SETTLE_CYC = 4,
    parameter int DRAIN_CYC  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    puf_eval_ctrl_if.slave       bus,
    output logic [N-1:0]         o_puf_sel,
    output logic                 o_puf_in,
    output logic                 o_puf_reset,
    input  logic [15:0]          i_cnt_a,
    input  logic [15:0]          i_cnt_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_EXCITE,
        S_DRAIN,
        S_COMPARE,
        S_HOLD
    } state_t;

    // Last value of the per-state cycle counter before leaving each timed state.
    localparam logic [15:0] CLEAR_LAST  = 16'd1;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] EXCITE_LAST = 16'(2 * PULSES - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(DRAIN_CYC - 1);

    state_t       r_state;
    logic [15:0]  r_cyc;
    logic [N-1:0] r_puf_sel;
    logic         r_puf_in;
    logic         r_puf_reset;
    logic         r_resp_bit;
    logic [15:0]  r_resp_margin;

    state_t       w_state_nxt;
    logic [15:0]  w_cyc_nxt;
    logic         w_capture;
    logic         w_final;
    logic         w_puf_in_nxt;
    logic         w_puf_reset_nxt;
    logic         w_gt;
    logic [15:0]  w_margin;
    logic         w_res_bit;
    logic [15:0]  w_res_margin;

    // Per-round comparison of the two counters. The subtraction is always
    // larger-minus-smaller, so the 16-bit difference equals the exact
    // unsigned result and can never wrap.
    always_comb begin
        w_gt     = (i_cnt_a > i_cnt_b);
        w_margin = (i_cnt_a >= i_cnt_b) ? (i_cnt_a - i_cnt_b) : (i_cnt_b - i_cnt_a);
    end

`ifdef PUF_MAJORITY_EN
    logic [1:0]  r_round;
    logic [1:0]  r_bits;
    logic [15:0] r_min;
    logic        w_round_adv;
    logic        w_last_round;

    assign w_last_round = (r_round == 2'd2);

    // Round bookkeeping for the three-round vote: remembers the first two
    // round bits and the running minimum margin. Cleared on every accepted
    // start so a new evaluation never inherits old rounds.
    always_ff @(posedge clk) begin
        if (reset || w_capture) begin
            r_round <= 2'd0;
            r_bits  <= 2'b00;
            r_min   <= 16'd0;
        end else if (w_round_adv) begin
            if (r_round == 2'd0) begin
                r_bits[0] <= w_gt;
                r_min     <= w_margin;
            end else begin
                r_bits[1] <= w_gt;
                r_min     <= (w_margin < r_min) ? w_margin : r_min;
            end
            r_round <= r_round + 2'd1;
        end
    end

    // Final result combines the two stored rounds with the round being
    // compared right now.
    always_comb begin
        w_res_bit    = (r_bits[0] & r_bits[1]) | (r_bits[0] & w_gt) | (r_bits[1] & w_gt);
        w_res_margin = (w_margin < r_min) ? w_margin : r_min;
    end
`else
    // Single round: the result is simply this round's comparison.
    always_comb begin
        w_res_bit    = w_gt;
        w_res_margin = w_margin;
    end
`endif

    // Next-state logic. Every timed state counts r_cyc from zero and hands
    // over with the counter cleared, so the following state starts at
    // index 0. The chain drive outputs are decoded from the next state so
    // they are registered alongside the state itself.
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc + 16'd1;
        w_capture   = 1'b0;
        w_final     = 1'b0;
`ifdef PUF_MAJORITY_EN
        w_round_adv = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cyc_nxt = 16'd0;
                if (bus.start) begin
                    w_state_nxt = S_CLEAR;
                    w_capture   = 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_cyc == CLEAR_LAST) begin
                    w_state_nxt = S_SETTLE;
                    w_cyc_nxt   = 16'd0;
                end
            end
            S_SETTLE: begin
                if (r_cyc == SETTLE_LAST) begin
                    w_state_nxt = S_EXCITE;
                    w_cyc_nxt   = 16'd0;
                end
            end
            S_EXCITE: begin
                if (r_cyc == EXCITE_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_cyc_nxt   = 16'd0;
                end
            end
            S_DRAIN: begin
                if (r_cyc == DRAIN_LAST) begin
                    w_state_nxt = S_COMPARE;
                    w_cyc_nxt   = 16'd0;
                end
            end
            S_COMPARE: begin
                w_cyc_nxt = 16'd0;
`ifdef PUF_MAJORITY_EN
                if (w_last_round) begin
                    w_state_nxt = S_HOLD;
                    w_final     = 1'b1;
                end else begin
                    w_state_nxt = S_CLEAR;
                    w_round_adv = 1'b1;
                end
`else
                w_state_nxt = S_HOLD;
                w_final     = 1'b1;
`endif
            end
            S_HOLD: begin
                w_cyc_nxt = 16'd0;
                if (bus.resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = 16'd0;
            end
        endcase

        // Pulse high on even excite indices, so the train starts high and
        // ends low after exactly PULSES rising edges.
        w_puf_in_nxt    = (w_state_nxt == S_EXCITE) && !w_cyc_nxt[0];
        w_puf_reset_nxt = (w_state_nxt == S_CLEAR);
    end

    // State, counter and all registered outputs. Reset clears everything
    // except the counter clear, which is held asserted so the chain counters
    // stay cleared while the controller is in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cyc         <= 16'd0;
            r_puf_sel     <= '0;
            r_puf_in      <= 1'b0;
            r_puf_reset   <= 1'b1;
            r_resp_bit    <= 1'b0;
            r_resp_margin <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cyc       <= w_cyc_nxt;
            r_puf_in    <= w_puf_in_nxt;
            r_puf_reset <= w_puf_reset_nxt;
            if (w_capture) begin
                r_puf_sel <= bus.challenge;
            end
            if (w_final) begin
                r_resp_bit    <= w_res_bit;
                r_resp_margin <= w_res_margin;
            end
        end
    end

    assign o_puf_sel       = r_puf_sel;
    assign o_puf_in        = r_puf_in;
    assign o_puf_reset     = r_puf_reset;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.resp_valid  = (r_state == S_HOLD);
    assign bus.resp_bit    = r_resp_bit;
    assign bus.resp_margin = r_resp_margin;

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Evaluation controller for the dual-mode demux/mux PUF delay chain. It accepts a challenge and drives it onto the chain's select lines. It clears the two 16-bit end-of-chain pulse counters, launches a fixed excitation pulse train into the chain input, then reads both counters and compares them. The result is one response bit plus a confidence margin, returned over a valid/ready handshake.

## Interface
- N, 128: challenge width; equals the chain stage count.
- PULSES, 64: excitation pulses per round; legal range 1..32767.
- SETTLE_CYC, 4: cycles between select load and the first pulse; minimum 1.
- DRAIN_CYC, 8: cycles after the last pulse before counters are sampled; minimum 1.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request evaluation; sampled only in IDLE.
- challenge  in  N  challenge vector; captured on the accepted start.
- busy  out  1  high in every state except IDLE.
- puf_sel  out  N  registered select vector to the chain.
- puf_in  out  1  registered excitation drive to the chain input.
- puf_reset  out  1  registered clear to both chain counters.
- cnt_a  in  16  counter value at the m-path end.
- cnt_b  in  16  counter value at the n-path end.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_bit  out  1  response bit.
- resp_margin  out  16  |cnt_a − cnt_b| for the reported round.

## Operation
- States, in order: IDLE, CLEAR, SETTLE, EXCITE, DRAIN, COMPARE, HOLD.
- IDLE:
  - start=1 captures challenge into puf_sel and moves to CLEAR.
  - start while not in IDLE is ignored; it is not queued.
- CLEAR: puf_reset=1 for exactly 2 cycles, then SETTLE.
- SETTLE: SETTLE_CYC cycles with puf_in=0.
- EXCITE:
  - 2·PULSES cycles.
  - puf_in=1 on even cycle index and 0 on odd, starting at 1.
  - Exactly PULSES rising edges; puf_in ends at 0.
- DRAIN: DRAIN_CYC cycles with puf_in=0, letting the chain settle.
- COMPARE, 1 cycle; cnt_a and cnt_b are sampled as unsigned 16-bit:
  - resp_bit = (cnt_a > cnt_b); a tie gives 0.
  - resp_margin = cnt_a − cnt_b if cnt_a ≥ cnt_b, else cnt_b − cnt_a.
  - Computed in 17 bits, no wrap.
- HOLD:
  - resp_valid=1; resp_bit and resp_margin are stable.
  - On resp_valid && resp_ready, go to IDLE next cycle and drop resp_valid.
  - resp_ready is ignored outside HOLD.
- puf_sel holds the captured challenge through HOLD and retains it in IDLE until the next accepted start.
- Changes on challenge after capture have no effect.

## Timing
- Reset values:
  - state IDLE; busy 0; puf_sel 0; puf_in 0.
  - puf_reset 1 while reset is asserted, 0 from the first cycle after release.
  - resp_valid 0; resp_bit 0; resp_margin 0.
- Round length R = 2 + SETTLE_CYC + 2·PULSES + DRAIN_CYC + 1; defaults give R = 143.
- start sampled at edge k: busy=1 and puf_reset=1 from cycle k+1; resp_valid=1 from cycle k+R+1.
- Handshake:
  - resp_ready already high when resp_valid rises completes the transfer in that cycle.
  - busy=0 the next cycle.
  - Earliest next start is accepted one cycle later.
- Back-to-back: minimum start-to-start spacing is R+2 cycles.
- Reset mid-operation:
  - Aborts immediately; all outputs take reset values the next cycle.
  - Any pending response is discarded.
- Reset and start asserted together: reset wins.

## Configuration
- PUF_MAJORITY_EN defined:
  - Runs 3 rounds, each CLEAR→COMPARE with the same challenge.
  - resp_bit = majority of the 3 round bits.
  - resp_margin = minimum of the 3 round margins.
  - HOLD is entered only after round 3; resp_valid rises 3R+1 cycles after start (429 + 1 with defaults).
- PUF_MAJORITY_EN undefined: single round, behaviour exactly as above; no vote or round-counter logic is synthesized.

## Test plan
- Reset release, then idle for 10 cycles:
  - puf_reset=1 during reset, 0 after; all other outputs 0; busy 0.
- Default run, challenge=all-ones, counter model returns cnt_a=64, cnt_b=60:
  - Exactly 64 puf_in rising edges.
  - resp_valid at cycle 144 after start; resp_bit=1; resp_margin=4.
- Tie, cnt_a=cnt_b=0x8000: resp_bit=0, resp_margin=0.
- Extremes, cnt_a=0x0000, cnt_b=0xFFFF: resp_bit=0, resp_margin=0xFFFF.
- Backpressure:
  - resp_ready held 0 for 20 cycles: resp_valid, resp_bit and resp_margin stay stable.
  - start pulses during that window are ignored; one transfer occurs when resp_ready rises.
- Reset asserted in EXCITE cycle 30:
  - Next cycle puf_in=0, busy=0, resp_valid=0.
  - Subsequent start runs a full clean round.
- With PUF_MAJORITY_EN, round bits 1,0,1 with margins 7,3,9:
  - resp_bit=1, resp_margin=3.
  - resp_valid 430 cycles after start.
